// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: CPU-side bus of the interrupt controller (requests, boundary info, pulses, status).
interface irq_ctrl_if #(
    parameter int NUM_SRC = 3,
    parameter int PC_W    = 32
);
    logic [NUM_SRC-1:0] irq_req, mask_din, pending, in_service, mask;
    logic               inst_done, eret, mask_we, irq_take, eret_take;
    logic [PC_W-1:0]    pc_next, irq_vector, eret_pc;

    modport master (
        output irq_req, inst_done, pc_next, eret, mask_we, mask_din,
        input  irq_take, irq_vector, eret_take, eret_pc, pending, in_service, mask
    );
    modport slave (
        input  irq_req, inst_done, pc_next, eret, mask_we, mask_din,
        output irq_take, irq_vector, eret_take, eret_pc, pending, in_service, mask
    );
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: vectored fixed-priority interrupt controller with return-PC stack.
// Define NESTED_IRQ_EN to let higher-priority sources preempt active handlers.
module irq_ctrl #(
    parameter int              NUM_SRC      = 3,
    parameter int              PC_W         = 32,
    parameter logic [PC_W-1:0] HANDLER_BASE = 'h100,
    parameter logic [PC_W-1:0] VEC_STRIDE   = 'h20
) (
    input logic       clk,
    input logic       rst_n,
    irq_ctrl_if.slave bus
);
    localparam int IW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {RUN, TAKE, RET} state_e;

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] req_prev_q, pending_q, pending_d, in_service_q, in_service_d;
    logic [NUM_SRC-1:0] mask_q, mask_d, elig, win_oh;
    logic [IW-1:0]      win;
    logic [PC_W-1:0]    vector_q, vector_d, eret_pc_q, eret_pc_d, top;
    logic               do_ret, do_take;

    always_comb begin
        elig   = '0;
        win    = '0;
        win_oh = '0;
        for (int i = 0; i < NUM_SRC; i++)
`ifdef NESTED_IRQ_EN
            elig[i] = pending_q[i] & ~mask_q[i] & ~|(in_service_q & NUM_SRC'((2 << i) - 1));
`else
            elig[i] = pending_q[i] & ~mask_q[i] & ~|in_service_q;
`endif
        // descending scan so the lowest eligible index is written last
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (elig[i]) begin
                win    = IW'(i);
                win_oh = NUM_SRC'(1) << i;
            end
    end

    always_comb begin
        do_ret       = state_q == RUN && bus.inst_done && bus.eret && |in_service_q;
        do_take      = state_q == RUN && bus.inst_done && |elig && !do_ret;
        state_d      = do_ret ? RET : do_take ? TAKE : RUN;
        pending_d    = (pending_q | (bus.irq_req & ~req_prev_q)) & ~(do_take ? win_oh : '0);
        in_service_d = do_ret ? in_service_q & (in_service_q - 1'b1)
                     : do_take ? in_service_q | win_oh : in_service_q;
        mask_d       = bus.mask_we ? bus.mask_din : mask_q;
        vector_d     = do_take ? HANDLER_BASE + PC_W'(win) * VEC_STRIDE : vector_q;
        eret_pc_d    = do_ret ? top : eret_pc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            req_prev_q   <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
            mask_q       <= '0;
            vector_q     <= '0;
            eret_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            req_prev_q   <= bus.irq_req;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            mask_q       <= mask_d;
            vector_q     <= vector_d;
            eret_pc_q    <= eret_pc_d;
        end
    end

`ifdef NESTED_IRQ_EN
    localparam int CW = $clog2(NUM_SRC + 1);
    logic [CW-1:0]   depth;
    logic [PC_W-1:0] stack_q [NUM_SRC];

    always_comb begin
        depth = '0;
        for (int i = 0; i < NUM_SRC; i++) depth = depth + CW'(in_service_q[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SRC; i++) stack_q[i] <= '0;
        end else if (do_take) begin
            stack_q[IW'(depth)] <= bus.pc_next;
        end
    end

    assign top = stack_q[IW'(depth - 1'b1)];
`else
    logic [PC_W-1:0] stack_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stack_q <= '0;
        else if (do_take) stack_q <= bus.pc_next;
    end

    assign top = stack_q;
`endif

    assign bus.irq_take   = state_q == TAKE;
    assign bus.eret_take  = state_q == RET;
    assign bus.irq_vector = vector_q;
    assign bus.eret_pc    = eret_pc_q;
    assign bus.pending    = pending_q;
    assign bus.in_service = in_service_q;
    assign bus.mask       = mask_q;
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scenarios; expected pulses are queued by stimulus and checked by a monitor.
module tb_irq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    typedef struct {
        logic        ret;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    irq_ctrl_if #(.NUM_SRC(3), .PC_W(32)) bus ();

    irq_ctrl #(
        .NUM_SRC(3), .PC_W(32), .HANDLER_BASE(32'h100), .VEC_STRIDE(32'h20)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && bus.irq_take && bus.eret_take) begin
            n_chk++;
            n_fail++;
            $display("FAIL both_pulses: irq_take and eret_take high together at %0t", $time);
        end
        if (rst_n && (bus.irq_take || bus.eret_take)) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: eret_take=%0b irq_vector=%h eret_pc=%h, none expected at %0t",
                         bus.eret_take, bus.irq_vector, bus.eret_pc, $time);
            end else begin
                e = sb.pop_front();
                if (e.ret != bus.eret_take || e.pc != (bus.eret_take ? bus.eret_pc : bus.irq_vector)) begin
                    n_fail++;
                    $display("FAIL pulse: got eret=%0b pc=%h, expected eret=%0b pc=%h at %0t",
                             bus.eret_take, bus.eret_take ? bus.eret_pc : bus.irq_vector, e.ret, e.pc, $time);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic ret, input logic [31:0] pc);
        sb.push_back('{ret: ret, pc: pc});
    endtask

    task automatic do_eret(input logic [31:0] pc);
        push(1'b1, pc);
        bus.eret = 1'b1;
        tick(1);
        bus.eret = 1'b0;
        tick(1);
    endtask

    task automatic take(input logic [2:0] req, input logic [31:0] pc, input logic [31:0] vec);
        bus.irq_req = req;
        bus.pc_next = pc;
        push(1'b0, vec);
        tick(2);
    endtask

    initial begin
        bus.irq_req = '0; bus.inst_done = 1'b1; bus.pc_next = '0;
        bus.eret = 1'b0; bus.mask_we = 1'b0; bus.mask_din = '0;
        tick(2);
        check("reset_pending", bus.pending, 0);
        check("reset_irq_take", bus.irq_take, 0);
        rst_n = 1'b1;
        tick(1);

        // mid-handler reset with a blocked source pending
        take(3'b010, 32'h2000, 32'h120);
        bus.irq_req = 3'b110; bus.mask_we = 1'b1; bus.mask_din = 3'b100;
        tick(1);
        bus.mask_we = 1'b0;
        tick(1);
        check("pre_reset_pending", bus.pending, 3'b100);
        check("pre_reset_in_service", bus.in_service, 3'b010);
        #2 rst_n = 1'b0;
        #1;
        check("rst_pending", bus.pending, 0);
        check("rst_in_service", bus.in_service, 0);
        check("rst_mask", bus.mask, 0);
        check("rst_vector", bus.irq_vector, 0);
        check("rst_pulses", {bus.irq_take, bus.eret_take}, 0);
        bus.irq_req = '0;
        tick(2);
        rst_n = 1'b1;
        tick(6);
        check("post_rst_pending", bus.pending, 0);

        // basic take and return
        bus.irq_req = 3'b010; bus.pc_next = 32'h3004; push(1'b0, 32'h120);
        tick(1);
        check("t2_pending", bus.pending, 3'b010);
        check("t2_no_take_yet", bus.irq_take, 0);
        tick(1);
        check("t2_in_service", bus.in_service, 3'b010);
        check("t2_pending_clr", bus.pending, 0);
        check("t2_irq_take", bus.irq_take, 1);
        tick(1);
        push(1'b1, 32'h3004);
        bus.eret = 1'b1;
        tick(1);
        bus.eret = 1'b0;
        check("t3_in_service", bus.in_service, 0);
        check("t3_eret_take", bus.eret_take, 1);
        tick(4);
        check("t3_level_no_retrigger", bus.pending, 0);

        // nesting / no nesting
        bus.irq_req = '0;
        tick(1);
        take(3'b010, 32'h3004, 32'h120);
        bus.irq_req = 3'b111; bus.pc_next = 32'h124;
`ifdef NESTED_IRQ_EN
        push(1'b0, 32'h100);
        tick(2);
        check("t4_in_service", bus.in_service, 3'b011);
        check("t4_pending", bus.pending, 3'b100);
        tick(1);
        do_eret(32'h124);
        check("t4_in_service_pop1", bus.in_service, 3'b010);
        check("t4_pending_hold", bus.pending, 3'b100);
        do_eret(32'h3004);
        push(1'b0, 32'h140);
        tick(1);
        check("t4_in_service_irq2", bus.in_service, 3'b100);
        tick(1);
        do_eret(32'h124);
`else
        tick(2);
        check("t4_in_service", bus.in_service, 3'b010);
        check("t4_pending", bus.pending, 3'b101);
        tick(3);
        check("t4_pending_held", bus.pending, 3'b101);
        do_eret(32'h3004);
        push(1'b0, 32'h100);
        tick(1);
        check("t4_in_service_irq0", bus.in_service, 3'b001);
        check("t4_pending_irq2", bus.pending, 3'b100);
        tick(1);
        do_eret(32'h124);
        push(1'b0, 32'h140);
        tick(2);
        do_eret(32'h124);
`endif
        check("t4_idle", bus.in_service, 0);

        // mask
        bus.irq_req = '0; bus.mask_we = 1'b1; bus.mask_din = 3'b001; bus.pc_next = 32'h5000;
        tick(1);
        bus.mask_we = 1'b0;
        check("t5_mask", bus.mask, 3'b001);
        bus.irq_req = 3'b001;
        tick(1);
        check("t5_pending", bus.pending, 3'b001);
        tick(10);
        check("t5_masked_pending", bus.pending, 3'b001);
        check("t5_masked_in_service", bus.in_service, 0);
        push(1'b0, 32'h100);
        bus.mask_we = 1'b1; bus.mask_din = 3'b000;
        tick(1);
        bus.mask_we = 1'b0;
        tick(1);
        check("t5_in_service", bus.in_service, 3'b001);
        tick(1);
        do_eret(32'h5000);

        // eret beats a simultaneous take
        bus.irq_req = '0;
        tick(1);
        take(3'b010, 32'h3004, 32'h120);
        bus.irq_req = 3'b011; bus.pc_next = 32'h6000;
        tick(1);
        push(1'b1, 32'h3004);
        push(1'b0, 32'h100);
        bus.eret = 1'b1;
        tick(1);
        bus.eret = 1'b0;
        check("t6_ret_first_in_service", bus.in_service, 0);
        check("t6_req_still_pending", bus.pending, 3'b001);
        tick(2);
        check("t6_take_after", bus.in_service, 3'b001);
        tick(1);
        do_eret(32'h6000);

        // no decisions without inst_done
        bus.irq_req = '0;
        tick(1);
        bus.inst_done = 1'b0; bus.irq_req = 3'b100; bus.pc_next = 32'h7000;
        tick(5);
        check("t6_idle_pending", bus.pending, 3'b100);
        check("t6_idle_in_service", bus.in_service, 0);
        push(1'b0, 32'h140);
        bus.inst_done = 1'b1;
        tick(1);
        check("t6_boundary_take", bus.in_service, 3'b100);
        tick(1);
        do_eret(32'h7000);

        // eret with nothing in service is ignored
        bus.eret = 1'b1;
        tick(2);
        bus.eret = 1'b0;
        check("eret_idle_in_service", bus.in_service, 0);
        tick(3);
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Vectored interrupt controller for the single-cycle MIPS CPU; sits beside the instruction decoder and PC select logic.
- Latches rising-edge requests from NUM_SRC sources and arbitrates them by fixed priority (index 0 highest).
- Redirects the PC to a per-source handler at instruction boundaries, keeps a stack of return PCs, and returns on an ERET-class decode.

Parameters:
NUM_SRC, 3, number of interrupt sources (1..8)
PC_W, 32, PC width
HANDLER_BASE, 32'h0000_0100, vector of source 0
VEC_STRIDE, 32'h20, byte distance between consecutive source vectors

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
irq_req  in  NUM_SRC  request levels, already synchronous to clk
inst_done  in  1  instruction commits this cycle (boundary)
pc_next  in  PC_W  PC the CPU would load at this boundary
eret  in  1  decoded return-from-interrupt instruction
mask_we  in  1  write enable for mask register
mask_din  in  NUM_SRC  new mask value (1 = masked)
irq_take  out  1  one-cycle pulse: CPU loads irq_vector and suppresses all writes that cycle
irq_vector  out  PC_W  handler address, valid while irq_take=1
eret_take  out  1  one-cycle pulse: CPU loads eret_pc
eret_pc  out  PC_W  popped return PC, valid while eret_take=1
pending  out  NUM_SRC  latched, not-yet-serviced requests
in_service  out  NUM_SRC  sources whose handlers are active
mask  out  NUM_SRC  current mask register

Behaviour:
- Clock and reset: already decided — one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values:
  - All outputs 0.
  - Internal irq_req_d = 0, stack empty, state RUN.
  - Reset mid-handler discards all pending, in-service and stack state.
- Edge capture:
  - pending[i] sets at the edge where irq_req[i] & ~irq_req_d[i]; visible one cycle after irq_req rises.
  - Held levels do not re-trigger.
  - An edge on a source already pending is absorbed, not counted.
- Mask:
  - mask_we loads mask_din at the edge.
  - Masked sources still latch pending; they are only ineligible for take.
- Eligibility: pending[i] & ~mask[i] & (in_service[j]==0 for all j<=i). The winner is the lowest eligible index.
- FSM states: RUN, TAKE, RET.
  - RUN -> RET: edge with inst_done & eret & (in_service!=0). This has priority over a take decided at the same edge; that request is re-evaluated at the next boundary.
  - RUN -> TAKE: edge with inst_done & eligible winner w & no RET transition. At this edge:
    - push pc_next onto the stack;
    - set in_service[w], clear pending[w];
    - register irq_vector = HANDLER_BASE + w*VEC_STRIDE.
  - TAKE: irq_take=1 for exactly one cycle, then return to RUN. No decision is made in TAKE.
  - RET: eret_take=1 for exactly one cycle; eret_pc = popped top of stack, registered at the RUN->RET edge. At that edge, clear the lowest set bit of in_service. Then return to RUN.
- eret with in_service==0: ignored, no pulse, state RUN.
- inst_done=0: no take or return decision; pending continues to accumulate.
- Latency: request rise at edge n, pending at n+1, earliest irq_take high in the cycle after edge n+2 (given inst_done=1).
- Stack:
  - Depth NUM_SRC, LIFO, index = popcount(in_service).
  - Overflow is impossible by the eligibility rule.
- irq_take and eret_take are never high in the same cycle.

Optional Feature:
- NESTED_IRQ_EN defined: behaviour as above; a higher-priority source preempts an active lower-priority handler, up to NUM_SRC deep.
- NESTED_IRQ_EN undefined:
  - Eligibility additionally requires in_service==0.
  - The stack collapses to a single PC_W register.
  - in_service is one-hot or zero.
  - All other timing is identical.

Test Plan:
(All scenarios use NUM_SRC=3, HANDLER_BASE=0x100, VEC_STRIDE=0x20.)
1. Assert rst_n=0 mid-handler with pending=3'b100 -> all outputs 0 immediately; after release no irq_take without a new edge.
2. irq_req[1] rises, inst_done=1, pc_next=0x3004 -> pending=3'b010 next cycle; then irq_take pulse with irq_vector=0x120, in_service=3'b010, pending=0.
3. From (2), eret & inst_done -> eret_take one cycle, eret_pc=0x3004, in_service=0.
4. Nested (NESTED_IRQ_EN on):
   - in_service=3'b010; irq_req[0] at pc_next=0x124 -> irq_vector=0x100, in_service=3'b011.
   - irq_req[2] stays pending.
   - eret -> eret_pc=0x124; eret -> eret_pc=0x3004; next boundary -> irq_vector=0x140.
   - Without macro: irq 0 stays pending until the first eret.
5. mask=3'b001 written, irq_req[0] rises -> pending[0]=1, no irq_take for 10 cycles; mask_we with 0 -> irq_take, irq_vector=0x100.
6. eret and a new eligible request at the same edge -> eret_take first, irq_take after; with inst_done=0 for 5 cycles -> no pulses until inst_done=1.
